// File: rtl/result_bcd_converter_if.sv
// Request/result bundle between the result register, the BCD converter and the display driver.
interface result_bcd_converter_if #(
  parameter int bits   = 8,
  parameter int digits = 3
) ();
  logic                  start;
  logic [bits-1:0]       value;
  logic                  busy;
  logic                  done;
  logic [4*digits-1:0]   bcd;
  logic                  neg;

  modport master (output start, value, input busy, done, bcd, neg);
  modport slave  (input start, value, output busy, done, bcd, neg);
endinterface

// File: rtl/result_bcd_converter.sv
// Sequential double-dabble converter: one result bit per clock, holds the last
// published BCD/sign for the display until the next conversion completes.
module result_bcd_converter #(
  parameter int bits      = 8,
  parameter int digits    = 3,
  parameter bit signed_in = 1'b0
) (
  input logic                    clk,
  input logic                    reset,
  result_bcd_converter_if.slave  bus
);
  localparam int CW = $clog2(bits + 1);
  localparam int SW = 4 * digits;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t          state_q, state_d;
  logic [bits-1:0] mag_q, mag_d;
  logic [SW-1:0]   scratch_q, scratch_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sign_q, sign_d;
  logic [SW-1:0]   bcd_q, bcd_d;
  logic            neg_q, neg_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [SW-1:0]   adj;
  logic [SW-1:0]   scratch_shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mag_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      bcd_q     <= '0;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      sign_q    <= sign_d;
      bcd_q     <= bcd_d;
      neg_q     <= neg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = CONV;
      CONV:    if (cnt_q == CW'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Add-3 correction on every digit >= 5, then shift the magnitude MSB in.
  always_comb begin
    adj = scratch_q;
    for (int unsigned i = 0; i < digits; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
    scratch_shift = {adj[SW-2:0], mag_q[bits-1]};
  end

  always_comb begin
    mag_d     = mag_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    bcd_d     = bcd_q;
    neg_d     = neg_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (signed_in && bus.value[bits-1]) begin
            mag_d  = ~bus.value + bits'(1);
            sign_d = 1'b1;
          end else begin
            mag_d  = bus.value;
            sign_d = 1'b0;
          end
          scratch_d = '0;
          cnt_d     = CW'(bits);
        end
      end
      CONV: begin
        scratch_d = scratch_shift;
        mag_d     = mag_q << 1;
        cnt_d     = cnt_q - CW'(1);
        // Publish on the edge entering DONE so the display never sees partial digits.
        if (cnt_q == CW'(1)) begin
          bcd_d = scratch_shift;
          neg_d = sign_q;
        end
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
  assign bus.neg  = neg_q;
endmodule

// File: tb/tb_result_bcd_converter.sv
// Directed bench for result_bcd_converter: unsigned and signed instances, scoreboarded results.
module tb_result_bcd_converter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  result_bcd_converter_if #(.bits(8), .digits(3)) ifu ();
  result_bcd_converter_if #(.bits(8), .digits(3)) ifs ();

  result_bcd_converter #(.bits(8), .digits(3), .signed_in(1'b0)) dut_u (
    .clk(clk), .reset(reset), .bus(ifu.slave));
  result_bcd_converter #(.bits(8), .digits(3), .signed_in(1'b1)) dut_s (
    .clk(clk), .reset(reset), .bus(ifs.slave));

  int checks = 0;
  int failures = 0;
  int done_cnt_u = 0;
  logic [12:0] q_u[$];
  logic [12:0] q_s[$];
  logic [12:0] exp_u, exp_s;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ifu.done === 1'b1) begin
      done_cnt_u++;
      check("u_pending", 32'(q_u.size() != 0), 32'd1);
      if (q_u.size() != 0) begin
        exp_u = q_u.pop_front();
        check("u_bcd", 32'(ifu.bcd), 32'(exp_u[12:1]));
        check("u_neg", 32'(ifu.neg), 32'(exp_u[0]));
      end
    end
    if (ifs.done === 1'b1) begin
      check("s_pending", 32'(q_s.size() != 0), 32'd1);
      if (q_s.size() != 0) begin
        exp_s = q_s.pop_front();
        check("s_bcd", 32'(ifs.bcd), 32'(exp_s[12:1]));
        check("s_neg", 32'(ifs.neg), 32'(exp_s[0]));
      end
    end
  end

  task automatic conv(input bit sel, input logic [7:0] v, input logic [11:0] eb, input logic en);
    int busy_n, done_n, done_at;
    logic [11:0] prev;
    logic b, d;
    logic [11:0] bc;
    busy_n = 0; done_n = 0; done_at = 0;
    if (sel) begin
      q_s.push_back({eb, en}); ifs.value = v; ifs.start = 1'b1; prev = ifs.bcd;
    end else begin
      q_u.push_back({eb, en}); ifu.value = v; ifu.start = 1'b1; prev = ifu.bcd;
    end
    @(negedge clk);
    ifu.start = 1'b0; ifs.start = 1'b0;
    ifu.value = 8'hA5; ifs.value = 8'hA5;
    for (int i = 1; i <= 20; i++) begin
      b  = sel ? ifs.busy : ifu.busy;
      d  = sel ? ifs.done : ifu.done;
      bc = sel ? ifs.bcd  : ifu.bcd;
      if (b !== 1'b1) break;
      busy_n++;
      if (d === 1'b1) begin
        done_n++;
        done_at = i;
      end else if (done_n == 0) begin
        check("bcd_hold", 32'(bc), 32'(prev));
      end
      @(negedge clk);
    end
    check("busy_cycles", busy_n, 9);
    check("done_pulses", done_n, 1);
    check("done_cycle", done_at, 9);
  endtask

  initial begin
    int base, d1, d2;
    reset = 1'b1;
    ifu.start = 1'b0; ifu.value = '0;
    ifs.start = 1'b0; ifs.value = '0;
    #1;
    check("rst_busy", 32'(ifu.busy), 0);
    check("rst_done", 32'(ifu.done), 0);
    check("rst_bcd",  32'(ifu.bcd), 0);
    check("rst_neg",  32'(ifu.neg), 0);
    check("rst_s_bcd", 32'(ifs.bcd), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    conv(1'b0, 8'd255, 12'h255, 1'b0);
    conv(1'b0, 8'd0,   12'h000, 1'b0);
    conv(1'b0, 8'd9,   12'h009, 1'b0);
    conv(1'b0, 8'd100, 12'h100, 1'b0);
    conv(1'b0, 8'd199, 12'h199, 1'b0);

    conv(1'b1, 8'h80, 12'h128, 1'b1);
    conv(1'b1, 8'hFF, 12'h001, 1'b1);
    conv(1'b1, 8'h7F, 12'h127, 1'b0);
    conv(1'b1, 8'h00, 12'h000, 1'b0);

    // Requests during CONV and during DONE must be dropped.
    base = done_cnt_u;
    q_u.push_back({12'h042, 1'b0});
    ifu.value = 8'd42; ifu.start = 1'b1;
    @(negedge clk); ifu.start = 1'b0;
    repeat (2) @(negedge clk);
    ifu.value = 8'd99; ifu.start = 1'b1;
    @(negedge clk); ifu.start = 1'b0;
    repeat (5) @(negedge clk);
    check("ign_done_cycle", 32'(ifu.done), 1);
    ifu.start = 1'b1;
    @(negedge clk); ifu.start = 1'b0;
    check("ign_idle", 32'(ifu.busy), 0);
    repeat (12) @(negedge clk);
    check("ign_done_count", done_cnt_u - base, 1);
    check("ign_busy", 32'(ifu.busy), 0);
    check("ign_bcd", 32'(ifu.bcd), 32'h042);

    // Asynchronous reset partway through a conversion.
    ifu.value = 8'd200; ifu.start = 1'b1;
    @(negedge clk); ifu.start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy", 32'(ifu.busy), 1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(ifu.busy), 0);
    check("mid_rst_done", 32'(ifu.done), 0);
    check("mid_rst_bcd",  32'(ifu.bcd), 0);
    check("mid_rst_neg",  32'(ifu.neg), 0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    conv(1'b0, 8'd7, 12'h007, 1'b0);

    // start held high: accepted every bits+2 edges.
    q_u.push_back({12'h001, 1'b0});
    q_u.push_back({12'h002, 1'b0});
    d1 = 0; d2 = 0;
    ifu.value = 8'd1; ifu.start = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (ifu.done === 1'b1) begin
        if (d1 == 0) begin
          d1 = i;
          ifu.value = 8'd2;
        end else begin
          d2 = i;
          break;
        end
      end
    end
    ifu.start = 1'b0;
    check("b2b_first_done", d1, 9);
    check("b2b_second_done", d2, 19);
    repeat (4) @(negedge clk);
    check("b2b_idle", 32'(ifu.busy), 0);

    check("u_queue_drained", q_u.size(), 0);
    check("s_queue_drained", q_s.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/result_bcd_converter.md
# result_bcd_converter

Sequential binary-to-BCD converter that reads the calculator's result register and produces packed BCD digits plus a sign flag for the display driver. It accepts the register's `q` value on a one-cycle `start` request. It converts with the shift-and-add-3 (double-dabble) method, one bit per clock. It holds the last converted result stable for the display until the next conversion completes.

## Interface
Parameters:
- `bits`, default 8: width of the binary input value.
- `digits`, default 3: number of BCD output digits. Must satisfy 10^digits > 2^bits − 1 (unsigned case).
- `signed_in`, default 0: 1 means `value` is two's complement; 0 means unsigned.

Ports:
- `clk`, input, 1: single system clock. All state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: conversion request. Sampled only in IDLE.
- `value`, input, `bits`: binary operand, driven by the result register output. Sampled on the accepted `start` edge only.
- `busy`, output, 1: high while a conversion is in progress (CONV or DONE).
- `done`, output, 1: one-cycle pulse when `bcd`/`neg` update.
- `bcd`, output, 4*`digits`: packed BCD result. Digit 0 is in bits [3:0] (least significant).
- `neg`, output, 1: result sign. Always 0 when `signed_in`=0.

## Operation
- States:
  - IDLE: waiting for `start`.
  - CONV: shifting.
  - DONE: publish result.
- IDLE:
  - `start`=1 at an edge latches `value` into the shift register, clears the BCD scratch, loads the bit counter with `bits`, and moves to CONV.
  - If `signed_in`=1 and `value[bits-1]`=1, the latched magnitude is (~`value`+1) in `bits` unsigned width, and the pending sign is 1. The most negative value −2^(bits−1) yields magnitude 2^(bits−1) correctly.
  - Otherwise the magnitude is `value` unchanged and the pending sign is 0.
- CONV, each cycle:
  - In the scratch register, add 3 to every digit ≥5.
  - Then shift {scratch, magnitude} left by 1.
  - Decrement the counter.
  - After exactly `bits` CONV cycles, go to DONE.
- DONE:
  - `bcd` ← scratch, `neg` ← pending sign, `done`=1 for this one cycle.
  - Return to IDLE on the next edge.
- `start` while `busy`=1 (including the DONE cycle) is ignored. It is not queued.
- `bcd` and `neg` do not change during CONV. They change only on the edge entering DONE.
- Zero input converts to all-zero `bcd` with `neg`=0. This holds in signed mode too; there is no negative zero.

## Timing
- Reset values (asynchronous, immediate on `reset`=1): state IDLE, `busy`=0, `done`=0, `bcd`=0, `neg`=0, counter and scratch = 0.
- Reset mid-conversion: the conversion is aborted and every output returns to its reset value. `start` must be reasserted after `reset` deasserts.
- Let E0 be the edge sampling `start` in IDLE:
  - `busy`=1 from after E0.
  - `bcd`, `neg` and `done`=1 become valid after edge E0+`bits`.
  - `busy`=0 and `done`=0 after E0+`bits`+1.
- Latency: `bits`+1 cycles from start edge to the `done` cycle. Total occupancy is `bits`+1 cycles. For default `bits`=8: `done` is high in the cycle after E0+8.
- Back-to-back: a `start` held high or re-asserted in the first IDLE cycle after DONE is accepted at that edge. Minimum request spacing is `bits`+2 edges.
- `done` and `busy` are registered outputs; no combinational path from inputs.

## Test plan
- Unsigned full scale: `bits`=8, `signed_in`=0, `value`=8'd255, one-cycle `start` → `busy` high 9 cycles; `done` pulses once after edge E0+8; `bcd`=12'h255, `neg`=0; `bcd` unchanged before that edge.
- Zero and digit-boundary values: `value`=0 → `bcd`=12'h000. `value`=8'd9 → 12'h009. `value`=8'd100 → 12'h100. `value`=8'd199 → 12'h199.
- Signed extremes: `signed_in`=1. `value`=8'h80 → `bcd`=12'h128, `neg`=1. `value`=8'hFF → 12'h001, `neg`=1. `value`=8'h7F → 12'h127, `neg`=0.
- Ignored request: start 8'd42, then pulse `start` with `value`=8'd99 on E0+3 and again during the DONE cycle → only one `done` pulse; `bcd`=12'h042; state returns to IDLE.
- Reset mid-operation: start 8'd200, assert `reset` asynchronously between edges E0+4 and E0+5 → `busy`, `done`, `bcd`, `neg` go to 0 immediately without a clock edge. After release, start 8'd7 → `bcd`=12'h007 after the full `bits`+1 latency.
- Back-to-back: `start` held high continuously with `value` stepping 8'd1, 8'd2 → conversions accepted every 10 edges; results 12'h001, then 12'h002. Each `done` is exactly one cycle wide.
